// File: rtl/grf_wr_arbiter.sv
// Register-file write-port arbiter: pipeline W-stage writes share one port with a
// 2-entry buffer of secondary (MDU/CP0) writes. Optional trace: GRF_WR_ARB_TRACE_EN.
module grf_wr_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_we,
    input  logic [4:0]  w_wa,
    input  logic [31:0] w_wd,
    input  logic [31:0] w_pc,
    input  logic        m_valid,
    input  logic [4:0]  m_wa,
    input  logic [31:0] m_wd,
    input  logic [31:0] m_pc,
    output logic        m_ready,
    output logic        RegWrite,
    output logic [4:0]  WA,
    output logic [31:0] WD,
    output logic [31:0] PC,
    output logic [31:0] busy_mask,
    output logic        stall_req
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic        v;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;

    // slot 0 is the head; slots at or above cnt_q are held at zero
    ent_t [DEPTH-1:0] buf_q, buf_k, buf_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [3:0]       starve_q, starve_n;
    logic             stall_n;
    logic             head_occ, head_vld, grant_w, grant_h, pop, push;

    assign m_ready = (cnt_q != CW'(DEPTH));

    always_comb begin
        head_occ = (cnt_q != '0);
        head_vld = head_occ && buf_q[0].v;
        // a frozen pipeline re-presents its write, so it is ignored while stalling
        grant_w  = reset && !stall_req && w_we && (w_wa != '0);
        grant_h  = reset && head_vld && !grant_w;
        pop      = head_occ && (grant_h || !buf_q[0].v);
        push     = m_valid && m_ready && (m_wa != '0);
    end

    always_comb begin
        RegWrite = grant_w || grant_h;
        WA       = '0;
        WD       = '0;
        PC       = '0;
        if (grant_w) begin
            WA = w_wa;
            WD = w_wd;
            PC = w_pc;
        end else if (grant_h) begin
            WA = buf_q[0].wa;
            WD = buf_q[0].wd;
            PC = buf_q[0].pc;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if ((CW'(i) < cnt_q) && buf_q[i].v)
                busy_mask[buf_q[i].wa] = 1'b1;
        busy_mask[0] = 1'b0;
    end

    // kill applies to entries already buffered; this cycle's accept is younger
    always_comb begin
        buf_k = buf_q;
        for (int i = 0; i < DEPTH; i++)
            if (grant_w && (buf_q[i].wa == w_wa))
                buf_k[i].v = 1'b0;

        buf_n = buf_k;
        cnt_n = cnt_q;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++)
                buf_n[i] = buf_k[i+1];
            buf_n[DEPTH-1] = '0;
            cnt_n = cnt_q - 1'b1;
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++)
                if (cnt_n == CW'(i))
                    buf_n[i] = '{v: 1'b1, wa: m_wa, wd: m_wd, pc: m_pc};
            cnt_n = cnt_n + 1'b1;
        end
    end

    // stall also drops when the head is gone (killed/empty) so it cannot hang
    always_comb begin
        if (!head_occ || grant_h)
            starve_n = '0;
        else if (head_vld && (starve_q != 4'hF))
            starve_n = starve_q + 1'b1;
        else
            starve_n = starve_q;

        if (grant_h || !head_vld)
            stall_n = 1'b0;
        else if (starve_n >= 4'(STARVE_LIMIT))
            stall_n = 1'b1;
        else
            stall_n = stall_req;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q     <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            stall_req <= 1'b0;
        end else begin
            buf_q     <= buf_n;
            cnt_q     <= cnt_n;
            starve_q  <= starve_n;
            stall_req <= stall_n;
        end
    end

`ifdef GRF_WR_ARB_TRACE_EN
    always @(posedge clk)
        if (RegWrite)
            $display("%0t@%h: $%0d <= %h%s", $time, PC, WA, WD, grant_h ? " (m)" : "");
`endif

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Scoreboard bench for grf_wr_arbiter: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_grf_wr_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        w_we = 1'b0;
    logic [4:0]  w_wa = '0;
    logic [31:0] w_wd = '0, w_pc = '0;
    logic        m_valid = 1'b0;
    logic [4:0]  m_wa = '0;
    logic [31:0] m_wd = '0, m_pc = '0;
    logic        m_ready, RegWrite, stall_req;
    logic [4:0]  WA;
    logic [31:0] WD, PC, busy_mask;

    always #5 clk = ~clk;

    grf_wr_arbiter #(.DEPTH(2), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd), .w_pc(w_pc),
        .m_valid(m_valid), .m_wa(m_wa), .m_wd(m_wd), .m_pc(m_pc),
        .m_ready(m_ready), .RegWrite(RegWrite), .WA(WA), .WD(WD), .PC(PC),
        .busy_mask(busy_mask), .stall_req(stall_req)
    );

    typedef struct {
        bit rst_n; bit w_we; bit [4:0] w_wa; bit [31:0] w_wd, w_pc;
        bit m_valid; bit [4:0] m_wa; bit [31:0] m_wd, m_pc;
    } stim_t;
    typedef struct { bit v; bit [4:0] wa; bit [31:0] wd, pc; } ent_t;
    typedef struct { int cyc; bit [4:0] wa; bit [31:0] wd, pc; } exp_t;

    ent_t        mq[$];
    exp_t        sb[$];
    int          starve = 0;
    bit          stall = 1'b0;
    bit [31:0]   rf_model[32];
    bit [31:0]   rf_dut[32];
    int          checks = 0, failures = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    function automatic stim_t mk(bit we, bit [4:0] wwa, bit [31:0] wwd,
                                 bit mv, bit [4:0] mwa, bit [31:0] mwd);
        stim_t s;
        s.rst_n = 1'b1; s.w_we = we; s.w_wa = wwa; s.w_wd = wwd;
        s.w_pc = 32'h0040_0000 | ($urandom & 32'h0000_fffc);
        s.m_valid = mv; s.m_wa = mwa; s.m_wd = mwd;
        s.m_pc = 32'h0080_0000 | ($urandom & 32'h0000_fffc);
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endfunction

    function automatic stim_t rst();
        stim_t s;
        s = idle();
        s.rst_n = 1'b0;
        return s;
    endfunction

    // One clock cycle: drive, check registered outputs, predict grant, advance model.
    task automatic run(input stim_t s);
        bit [31:0] busy;
        bit w_ok, hv, hg, pop, mr;
        exp_t e;
        @(posedge clk);
        #1;
        reset = s.rst_n; w_we = s.w_we; w_wa = s.w_wa; w_wd = s.w_wd; w_pc = s.w_pc;
        m_valid = s.m_valid; m_wa = s.m_wa; m_wd = s.m_wd; m_pc = s.m_pc;
        cyc++;
        if (!s.rst_n) begin
            mq.delete();
            starve = 0;
            stall = 1'b0;
        end
        #1;
        mr = (mq.size() < 2);
        busy = '0;
        foreach (mq[i]) if (mq[i].v) busy[mq[i].wa] = 1'b1;
        busy[0] = 1'b0;
        chk("m_ready", {31'b0, m_ready}, {31'b0, mr});
        chk("busy_mask", busy_mask, busy);
        chk("stall_req", {31'b0, stall_req}, {31'b0, stall});
        if (!s.rst_n) return;

        w_ok = s.w_we && (s.w_wa != 0) && !stall;
        hv   = (mq.size() > 0) && mq[0].v;
        hg   = hv && !w_ok;
        if (w_ok) begin
            e = '{cyc, s.w_wa, s.w_wd, s.w_pc};
            sb.push_back(e);
            rf_model[s.w_wa] = s.w_wd;
        end else if (hg) begin
            e = '{cyc, mq[0].wa, mq[0].wd, mq[0].pc};
            sb.push_back(e);
            rf_model[mq[0].wa] = mq[0].wd;
        end
        pop = (mq.size() > 0) && (hg || !mq[0].v);
        if (mq.size() == 0 || hg) starve = 0;
        else if (hv && starve < 15) starve++;
        if (hg || !hv) stall = 1'b0;
        else if (starve >= LIMIT) stall = 1'b1;
        if (w_ok) foreach (mq[i]) if (mq[i].wa == s.w_wa) mq[i].v = 1'b0;
        if (pop) void'(mq.pop_front());
        if (s.m_valid && mr && s.m_wa != 0) mq.push_back('{1'b1, s.m_wa, s.m_wd, s.m_pc});
    endtask

    // Monitor: every grant the DUT presents is popped and compared, cycle included.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (RegWrite) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant cyc=%0d got WA=%0d WD=%h want no grant", cyc, WA, WD);
                end else begin
                    e = sb.pop_front();
                    chk("grant_cycle", cyc, e.cyc);
                    chk("WA", {27'b0, WA}, {27'b0, e.wa});
                    chk("WD", WD, e.wd);
                    chk("PC", PC, e.pc);
                end
                rf_dut[WA] = WD;
            end else begin
                chk("idle_zero", {27'b0, WA} | WD | PC, 32'd0);
                if (sb.size() > 0 && sb[0].cyc == cyc) begin
                    chk("grant_missed", {31'b0, RegWrite}, 32'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #2 reset = 1'b0;
        run(rst());
        run(rst());
        // m write $5 alone: buffered, granted next cycle
        run(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11));
        run(idle());
        run(idle());
        // buffered $3 killed by younger pipeline write
        run(mk(1'b1, 5'd9, 32'h99, 1'b1, 5'd3, 32'hA));
        run(mk(1'b1, 5'd3, 32'hB, 1'b0, 5'd0, 32'd0));
        run(idle());
        run(idle());
        chk("rf3_final", rf_dut[3], 32'hB);
        // fill buffer under continuous pipeline traffic until stall
        run(mk(1'b1, 5'd10, 32'h100, 1'b1, 5'd1, 32'h1));
        run(mk(1'b1, 5'd11, 32'h101, 1'b1, 5'd2, 32'h2));
        for (int i = 0; i < 10; i++)
            run(mk(1'b1, 5'(12 + i), 32'h200 + i, 1'b1, 5'd4, 32'h4));
        run(idle());
        run(idle());
        // m_wa == 0 handshake stores nothing
        run(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD));
        run(idle());
        // reset with two entries buffered
        run(mk(1'b1, 5'd20, 32'h20, 1'b1, 5'd6, 32'h6));
        run(mk(1'b1, 5'd21, 32'h21, 1'b1, 5'd8, 32'h8));
        run(rst());
        run(idle());
        run(idle());
        // w_we with w_wa == 0 leaves the port to the head
        run(mk(1'b1, 5'd9, 32'h9, 1'b1, 5'd7, 32'h7));
        run(mk(1'b1, 5'd0, 32'hBAD, 1'b0, 5'd0, 32'd0));
        run(idle());
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            stim_t s;
            s = mk(($urandom % 10) < 7, 5'($urandom % 8), $urandom,
                   $urandom % 2, 5'($urandom % 8), $urandom);
            if (($urandom % 100) == 0) s.rst_n = 1'b0;
            run(s);
        end
        for (int i = 0; i < 6; i++) run(idle());
        @(posedge clk);
        #5;
        chk("scoreboard_empty", sb.size(), 32'd0);
        for (int i = 1; i < 32; i++) chk("regfile", rf_dut[i], rf_model[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
